// File: rtl/dma_rd_burst_gen.sv
// rtl/dma_rd_burst_gen.sv - splits a DDR read transfer into 4 KB-safe AXI INCR burst requests and forwards returned beats
module dma_rd_burst_gen #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  total_words_i,
  input  logic [LEN_W-1:0]  max_len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              dma_valid_o,
  output logic [ADDR_W-1:0] dma_addr_o,
  output logic [LEN_W-1:0]  dma_len_o,
  input  logic              dma_ready_i,
  input  logic [DATA_W-1:0] dma_rdata_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o
);

  localparam int BYTES   = DATA_W / 8;
  localparam int BYTE_SH = $clog2(BYTES);
  // Beat-count width wide enough for remaining, max_len+1 and the 4 KB distance
  localparam int BW0     = (CNT_W > 13) ? CNT_W : 13;
  localparam int BW      = (BW0 > LEN_W + 1) ? BW0 : LEN_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_REQ, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [LEN_W-1:0]  max_len_q;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic [BW-1:0]     beats_q;
  logic              busy_q;
  logic              done_q;
  logic              dma_valid_q;
  logic [ADDR_W-1:0] dma_addr_q;
  logic [LEN_W-1:0]  dma_len_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;

  logic [12:0]       to_bound_d;
  logic [BW-1:0]     beats_d;
  logic [BW-1:0]     rem_ext;
  logic [BW-1:0]     len_ext;
  logic [BW-1:0]     bnd_ext;
  logic              burst_end;
  logic              xfer_end;

  // Size of the next burst: smallest of words left, max burst and beats to the 4 KB line
  always_comb begin
    to_bound_d = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> BYTE_SH;
    rem_ext    = BW'(remaining_q);
    len_ext    = BW'(max_len_q) + BW'(1);
    bnd_ext    = BW'(to_bound_d);
    beats_d    = rem_ext;
    if (len_ext < beats_d) beats_d = len_ext;
    if (bnd_ext < beats_d) beats_d = bnd_ext;
    burst_end  = dma_ready_i && (beat_cnt_q == dma_len_q);
    xfer_end   = (remaining_q == CNT_W'(beats_q));
  end

  // Transfer sequencer with registered request and output stream
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      max_len_q   <= '0;
      beat_cnt_q  <= '0;
      beats_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dma_valid_q <= 1'b0;
      dma_addr_q  <= '0;
      dma_len_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cur_addr_q  <= base_addr_i;
            remaining_q <= total_words_i;
            max_len_q   <= max_len_i;
            busy_q      <= 1'b1;
            if (total_words_i == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          dma_addr_q  <= cur_addr_q;
          dma_len_q   <= LEN_W'(beats_d - BW'(1));
          beats_q     <= beats_d;
          beat_cnt_q  <= '0;
          dma_valid_q <= 1'b1;
          state_q     <= S_REQ;
        end
        S_REQ: begin
          if (dma_ready_i) begin
            beat_cnt_q  <= beat_cnt_q + LEN_W'(1);
            out_valid_q <= 1'b1;
            out_data_q  <= dma_rdata_i;
            if (burst_end) begin
              // Drop the request immediately so the engine cannot replay this burst
              cur_addr_q  <= cur_addr_q + (ADDR_W'(beats_q) << BYTE_SH);
              remaining_q <= remaining_q - CNT_W'(beats_q);
              dma_valid_q <= 1'b0;
              if (xfer_end) begin
                out_last_q <= 1'b1;
                done_q     <= 1'b1;
                state_q    <= S_DONE;
              end else begin
                state_q <= S_CALC;
              end
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign dma_valid_o = dma_valid_q;
  assign dma_addr_o  = dma_addr_q;
  assign dma_len_o   = dma_len_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

endmodule

// File: doc/dma_rd_burst_gen.md
# dma_rd_burst_gen

Read-transfer sequencer that sits directly upstream of the AXI DMA read engine. It accepts one transfer command: base DDR address and total word count. It splits the transfer into AXI INCR bursts that respect a programmable maximum length and never cross a 4 KB boundary. It drives the engine's valid/addr/len request port and re-registers the returned beats as an output word stream with a transfer-level last flag and done pulse.

## Interface
Parameters:
- ADDR_W, `DDR_ADDR_W: DDR byte-address width.
- DATA_W, `MIG_BUS_W: beat width. BYTES = DATA_W/8, a power of two, at most 4096.
- LEN_W, `AXI_LEN_W: AXI burst-length field width.
- CNT_W, 20: total-word-count width.

Ports:
- clk, in, 1: single clock, all logic on posedge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: command strobe. Sampled only in IDLE.
- base_addr, in, ADDR_W: first byte address. Must be BYTES-aligned.
- total_words, in, CNT_W: number of beats to read.
- max_len, in, LEN_W: maximum AXI len field (beats−1).
- busy, out, 1: high from the accepted start until done.
- done, out, 1: one-cycle pulse at transfer end.
- dma_valid, out, 1: burst request to the read engine.
- dma_addr, out, ADDR_W: burst start address.
- dma_len, out, LEN_W: burst len (beats−1).
- dma_ready, in, 1: one pulse per returned beat.
- dma_rdata, in, DATA_W: beat data, valid with dma_ready.
- out_valid, out, 1: output word strobe.
- out_data, out, DATA_W: output word.
- out_last, out, 1: marks the final word of the transfer.

## Operation
- States are IDLE, CALC, REQ and DONE.
- IDLE
  - On start: latch base_addr into cur_addr, total_words into remaining, and max_len. Set busy.
  - If total_words==0, go to DONE. Otherwise go to CALC.
- CALC (one cycle)
  - to_bound = (4096 − cur_addr[11:0]) / BYTES. Width is 13 bits; cur_addr[11:0]==0 gives 4096/BYTES.
  - beats = min(remaining, max_len+1, to_bound).
  - Register dma_addr=cur_addr and dma_len=beats−1, truncated to LEN_W; the value always fits.
  - Clear beat_cnt and go to REQ.
- REQ
  - dma_valid=1 until the last beat of the burst is received. dma_addr and dma_len stay stable for the whole burst, because the engine compares its counter to dma_len during data.
  - Each dma_ready: beat_cnt++, and the beat is forwarded.
  - On the dma_ready where beat_cnt==dma_len:
    - cur_addr += beats·BYTES and remaining −= beats.
    - If the new remaining is 0, go to DONE; otherwise go to CALC.
    - dma_valid is low the next cycle, so the engine, back in its address phase, cannot reissue the old burst.
- DONE (one cycle): done=1 and busy=0 on exit; go to IDLE.
- Forwarding: out_valid<=dma_ready in REQ, out_data<=dma_rdata. out_last<=1 on the final beat of the transfer (remaining==beats and beat_cnt==dma_len).
- There is no output backpressure. Consumers must accept one word per cycle.
- start while busy is ignored. Latched config is immune to input changes after acceptance.
- dma_ready outside REQ is ignored and produces no output.

## Timing
- Reset: state IDLE. busy, done, dma_valid, out_valid and out_last are 0. dma_addr, dma_len and out_data are 0.
- rst mid-burst abandons the transfer; all outputs return to reset values the next cycle. The read engine shares rst.
- start at cycle t gives busy=1 at t+1 and CALC at t+1, then dma_valid=1 at t+2.
- Zero-length transfer: start at t gives DONE at t+1 and done=1 at t+1. dma_valid and out_valid never assert.
- Output latency is exactly 1 cycle: dma_ready at cycle c gives out_valid at c+1.
- Last beat at cycle c:
  - dma_valid=0 at c+1 (CALC or DONE).
  - If more data remains, the next burst has dma_valid=1 at c+2. The gap is exactly one cycle.
  - If the transfer is complete, out_last=1 and done=1 at c+1, busy=0 at c+2.
- Address arithmetic wraps modulo 2^ADDR_W. The caller guarantees no wrap.

## Test plan
- Single burst: base 0x0, total 4, max_len 15 → one request with addr 0x0, len 3. Four out_valid beats with data in order; out_last and done on the 4th output.
- Max-length split: base 0x0, total 40, max_len 15, BYTES=32 → requests (0x000, 15), (0x200, 15), (0x400, 7). dma_valid is low exactly one cycle between bursts. 40 outputs, out_last only on the 40th.
- 4 KB boundary: base 0xFC0, total 10, max_len 15 → requests (0xFC0, 1) then (0x1000, 7). No request spans 0x1000.
- Zero count and ignored start: total 0 → done one cycle after start with no dma_valid. A second start during a 40-word transfer → no effect, exactly 40 outputs.
- Irregular beats: dma_ready with random 0–3 cycle gaps, and spurious dma_ready while in IDLE → output count equals total_words. Spurious pulses produce no output. dma_addr and dma_len are stable throughout REQ.
- Reset mid-burst: rst asserted during the 2nd burst → next cycle all outputs 0 and state IDLE. A new start then runs a correct transfer.
